// File: rtl/unary_pkg.sv
// unary_pkg: shared FSM state type and width/window-length helpers for the unary stream decoder
package unary_pkg;
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic int cnt_w(input int size);
    return size + 1;
  endfunction
  function automatic int win_len(input int size);
    return 1 << size;
  endfunction
endpackage

// File: rtl/unary_lane_counter.sv
// unary_lane_counter: per-lane 1s counter and thermometer check; ports clk/reset, i_start (bit 0), i_accumulate, i_bit, o_acc_nxt/o_bad_nxt (totals including i_bit)
module unary_lane_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_accumulate,
  input  logic             i_bit,
  output logic [CNT_W-1:0] o_acc_nxt,
  output logic             o_bad_nxt
);
  logic [CNT_W-1:0] r_acc;
  logic             r_seen_zero;
  logic             r_bad;
  always_comb begin
    o_acc_nxt = r_acc + CNT_W'(i_bit);
    o_bad_nxt = r_bad | (r_seen_zero & i_bit);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_seen_zero <= 1'b0;
      r_bad       <= 1'b0;
    end else if (i_start) begin
      r_acc       <= CNT_W'(i_bit);
      r_seen_zero <= ~i_bit;
      r_bad       <= 1'b0;
    end else if (i_accumulate) begin
      r_acc       <= o_acc_nxt;
      r_seen_zero <= r_seen_zero | ~i_bit;
      r_bad       <= o_bad_nxt;
    end
  end
endmodule

// File: rtl/unary_stream_decoder.sv
// unary_stream_decoder: thermometer streams to binary counts; ports clk/reset, frame_start/unary_in window input, out_valid/out_ready/out_value/out_malformed result port, busy/overrun/frame_err status
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int LANES = 2,
  parameter int CNT_W = cnt_w(SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [LANES-1:0]       unary_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*CNT_W-1:0] out_value,
  output logic [LANES-1:0]       out_malformed,
  output logic                   busy,
  output logic                   overrun,
  output logic                   frame_err
);
  state_t                 r_state, w_state_nxt;
  logic [SIZE-1:0]        r_win_cnt;
  logic                   r_out_valid, r_overrun, r_frame_err;
  logic [LANES*CNT_W-1:0] r_out_value, w_acc_nxt;
  logic [LANES-1:0]       r_out_malformed, w_bad_nxt;
  logic                   w_start, w_accum, w_done, w_load;
  always_comb begin
    w_start     = (r_state == IDLE) & frame_start;
    w_accum     = r_state == ACCUM;
    w_done      = w_accum & (r_win_cnt == SIZE'(win_len(SIZE) - 1));
    w_load      = w_done & (~r_out_valid | out_ready);
    w_state_nxt = w_start ? ACCUM : w_done ? IDLE : r_state;
  end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    unary_lane_counter #(.CNT_W(CNT_W)) u_lane (
      .clk          (clk),
      .reset        (reset),
      .i_start      (w_start),
      .i_accumulate (w_accum),
      .i_bit        (unary_in[g]),
      .o_acc_nxt    (w_acc_nxt[g*CNT_W +: CNT_W]),
      .o_bad_nxt    (w_bad_nxt[g])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_win_cnt       <= '0;
      r_out_valid     <= 1'b0;
      r_out_value     <= '0;
      r_out_malformed <= '0;
      r_overrun       <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) r_win_cnt <= SIZE'(1);
      else if (w_accum) r_win_cnt <= r_win_cnt + SIZE'(1);
      if (w_load) begin
        r_out_valid     <= 1'b1;
        r_out_value     <= w_acc_nxt;
        r_out_malformed <= w_bad_nxt;
      end else if (out_ready) r_out_valid <= 1'b0;
      if (w_done & r_out_valid & ~out_ready) r_overrun <= 1'b1;
      if (w_accum & frame_start & ~w_done) r_frame_err <= 1'b1;
    end
  end
  assign out_valid     = r_out_valid;
  assign out_value     = r_out_value;
  assign out_malformed = r_out_malformed;
  assign busy          = w_accum;
  assign overrun       = r_overrun;
  assign frame_err     = r_frame_err;
endmodule

// File: tb/tb_unary_stream_decoder.sv
// tb_unary_stream_decoder: table-driven and sequence checks of unary_stream_decoder with a result scoreboard
module tb_unary_stream_decoder;
  localparam int SIZE = 2, LANES = 2, CNT_W = 3;
  logic clk = 0, reset = 1, frame_start = 0, out_ready = 0;
  logic [LANES-1:0] unary_in = '0;
  logic out_valid, busy, overrun, frame_err;
  logic [LANES*CNT_W-1:0] out_value;
  logic [LANES-1:0] out_malformed;
  unary_stream_decoder #(.SIZE(SIZE), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .unary_in      (unary_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_value     (out_value),
    .out_malformed (out_malformed),
    .busy          (busy),
    .overrun       (overrun),
    .frame_err     (frame_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [2:0] c0; logic [2:0] c1; logic [1:0] mal;} rec_t;
  typedef struct packed {logic [3:0] l0; logic [3:0] l1; rec_t e;} tv_t;
  rec_t q[$];
  tv_t tbl[5];
  int checks = 0, errors = 0, mdl_cnt = 0;
  logic mdl_busy = 0, exp_ovr = 0, exp_fe = 0, use_tbl = 0;
  logic [3:0] m0 = '0, m1 = '0;
  rec_t tbl_exp;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic rec_t model(input logic [3:0] a, input logic [3:0] b);
    rec_t r;
    int ca, cb;
    ca = 0;
    cb = 0;
    for (int i = 0; i < 4; i++) begin
      ca += int'(a[i]);
      cb += int'(b[i]);
    end
    r.c0  = 3'(ca);
    r.c1  = 3'(cb);
    r.mal = {b != 4'((1 << cb) - 1), a != 4'((1 << ca) - 1)};
    return r;
  endfunction
  task automatic step(input logic fs, input logic [1:0] u, input logic rdy);
    rec_t r;
    @(negedge clk);
    chk("busy", int'(busy), int'(mdl_busy));
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("overrun", int'(overrun), int'(exp_ovr));
    chk("frame_err", int'(frame_err), int'(exp_fe));
    frame_start = fs;
    unary_in    = u;
    out_ready   = rdy;
    if (q.size() != 0 && rdy) begin
      r = q.pop_front();
      chk("out_value lane0", int'(out_value[2:0]), int'(r.c0));
      chk("out_value lane1", int'(out_value[5:3]), int'(r.c1));
      chk("out_malformed", int'(out_malformed), int'(r.mal));
    end
    if (!mdl_busy) begin
      if (fs) begin
        mdl_busy = 1;
        mdl_cnt  = 1;
        m0[0]    = u[0];
        m1[0]    = u[1];
      end
    end else begin
      m0[mdl_cnt] = u[0];
      m1[mdl_cnt] = u[1];
      if (fs && mdl_cnt != 3) exp_fe = 1;
      if (mdl_cnt == 3) begin
        mdl_busy = 0;
        r = use_tbl ? tbl_exp : model(m0, m1);
        if (q.size() == 0) q.push_back(r);
        else exp_ovr = 1;
      end else mdl_cnt++;
    end
  endtask
  task automatic send_window(input logic [3:0] l0, input logic [3:0] l1, input logic [3:0] rdy, input logic [3:0] fs_extra);
    for (int b = 0; b < 4; b++) step(b == 0 || fs_extra[b], {l1[b], l0[b]}, rdy[b]);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset       = 1;
    frame_start = 0;
    unary_in    = '0;
    out_ready   = 0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_value", int'(out_value), 0);
    chk("reset out_malformed", int'(out_malformed), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(overrun), 0);
    chk("reset frame_err", int'(frame_err), 0);
    reset    = 0;
    q.delete();
    mdl_busy = 0;
    exp_ovr  = 0;
    exp_fe   = 0;
  endtask
  initial begin
    tbl[0] = '{l0: 4'b0011, l1: 4'b1111, e: '{c0: 3'd2, c1: 3'd4, mal: 2'b00}};
    tbl[1] = '{l0: 4'b0101, l1: 4'b0000, e: '{c0: 3'd2, c1: 3'd0, mal: 2'b01}};
    tbl[2] = '{l0: 4'b0000, l1: 4'b1001, e: '{c0: 3'd0, c1: 3'd2, mal: 2'b10}};
    tbl[3] = '{l0: 4'b1111, l1: 4'b0001, e: '{c0: 3'd4, c1: 3'd1, mal: 2'b00}};
    tbl[4] = '{l0: 4'b0000, l1: 4'b0010, e: '{c0: 3'd0, c1: 3'd1, mal: 2'b10}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      use_tbl = 1;
      tbl_exp = tbl[i].e;
      send_window(tbl[i].l0, tbl[i].l1, 4'b0000, 4'b0000);
      use_tbl = 0;
      step(0, 2'b00, 1);
      step(0, 2'b00, 0);
    end
    send_window(4'b0001, 4'b0011, 4'b0000, 4'b0000);
    send_window(4'b0111, 4'b0000, 4'b0000, 4'b0000);
    step(0, 2'b00, 0);
    step(0, 2'b00, 1);
    step(0, 2'b00, 0);
    step(0, 2'b00, 0);
    do_reset();
    send_window(4'b0011, 4'b0001, 4'b0000, 4'b0000);
    send_window(4'b1111, 4'b0101, 4'b1000, 4'b0000);
    step(0, 2'b00, 0);
    step(0, 2'b00, 1);
    step(0, 2'b00, 0);
    send_window(4'b0001, 4'b0111, 4'b0000, 4'b0010);
    step(0, 2'b00, 0);
    step(0, 2'b00, 1);
    step(0, 2'b00, 0);
    step(1, 2'b11, 0);
    step(0, 2'b11, 0);
    do_reset();
    step(0, 2'b00, 0);
    step(0, 2'b00, 0);
    step(0, 2'b00, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
